// File: rtl/rsa_pkg.sv
// rsa_pkg: shared constants and types for the RSA engine arbiter.
// Bit is the engine operand width and the default for the arbiter's W.
package rsa_pkg;

  // Operand/result width of the shared modular-exponentiation engine.
  localparam int Bit = 8;

  // Default engine watchdog limit in cycles (used only with RSA_ARB_TIMEOUT_EN).
  localparam int RSA_TIMEOUT_DEF = 1024;

  // Arbiter job sequencer states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    RESP    = 3'd4
  } rsa_arb_state_t;

endpackage

// File: rtl/rsa_rr_pick.sv
// rsa_rr_pick: combinational round-robin picker.
// Searches req starting at last+1 and wrapping modulo N; the first set bit wins.
module rsa_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] sel,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;

  // Walk the N candidates in priority order and keep only the first hit.
  always_comb begin
    grant = '0;
    sel   = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last) + k) % N);
      if (!any && req[idx]) begin
        any        = 1'b1;
        sel        = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rsa_arbiter.sv
// rsa_arbiter: round-robin scheduler sharing one RSA mod-exp engine
// (Y = A^B mod C) between N requesters. One job in flight at a time.
// Optional engine watchdog: define RSA_ARB_TIMEOUT_EN to enable the
// TIMEOUT-cycle limit and the resp_err flag; otherwise resp_err is 0.
module rsa_arbiter
  import rsa_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = Bit,
  parameter int TIMEOUT = RSA_TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  input  logic [N*W-1:0] req_c,
  output logic [N-1:0]   req_ack,
  output logic [N-1:0]   resp_valid,
  output logic [W-1:0]   resp_y,
  output logic           resp_err,
  output logic           eng_start,
  output logic [W-1:0]   eng_a,
  output logic [W-1:0]   eng_b,
  output logic [W-1:0]   eng_c,
  input  logic           eng_busy,
  input  logic [W-1:0]   eng_y
);

  localparam int IW = $clog2(N);

  rsa_arb_state_t state;
  logic [IW-1:0]  last;
  logic [IW-1:0]  sel;
  logic [N-1:0]   grant;
  logic [N-1:0]   owner;
  logic           any;
  logic           expired;

  logic [W-1:0] a_arr [N];
  logic [W-1:0] b_arr [N];
  logic [W-1:0] c_arr [N];

  // Unflatten the operand buses so the winner can be selected by index.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*W +: W];
      assign b_arr[gi] = req_b[gi*W +: W];
      assign c_arr[gi] = req_c[gi*W +: W];
    end
  endgenerate

  rsa_rr_pick #(.N(N)) u_pick (
    .req   (req),
    .last  (last),
    .grant (grant),
    .sel   (sel),
    .any   (any)
  );

`ifdef RSA_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          err;
  // Last wait cycle allowed: the job has then spent TIMEOUT cycles waiting.
  assign expired  = (wait_cnt == CW'(TIMEOUT - 1));
  assign resp_err = err;
`else
  localparam int timeout_unused = TIMEOUT;
  assign expired  = 1'b0;
  assign resp_err = 1'b0;
`endif

  // Job sequencer: arbitrate in IDLE, drive the engine handshake, return the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last       <= IW'(N - 1);
      owner      <= '0;
      req_ack    <= '0;
      resp_valid <= '0;
      resp_y     <= '0;
      eng_start  <= 1'b0;
      eng_a      <= '0;
      eng_b      <= '0;
      eng_c      <= '0;
`ifdef RSA_ARB_TIMEOUT_EN
      wait_cnt   <= '0;
      err        <= 1'b0;
`endif
    end else begin
      req_ack    <= '0;
      eng_start  <= 1'b0;
      resp_valid <= '0;
      case (state)
        IDLE: begin
          // The engine has no reset and may still be finishing an abandoned
          // job (after our reset or a watchdog expiry), so never start over it.
          if (any && !eng_busy) begin
            eng_a     <= a_arr[sel];
            eng_b     <= b_arr[sel];
            eng_c     <= c_arr[sel];
            last      <= sel;
            owner     <= grant;
            eng_start <= 1'b1;
            req_ack   <= grant;
            state     <= START;
          end
        end
        START: begin
          state <= WAIT_HI;
`ifdef RSA_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT_HI, WAIT_LO: begin
          if (state == WAIT_LO && !eng_busy) begin
            resp_y     <= eng_y;
            resp_valid <= owner;
            state      <= RESP;
`ifdef RSA_ARB_TIMEOUT_EN
            err        <= 1'b0;
`endif
          end else if (expired) begin
            resp_y     <= '0;
            resp_valid <= owner;
            state      <= RESP;
`ifdef RSA_ARB_TIMEOUT_EN
            err        <= 1'b1;
`endif
          end else if (state == WAIT_HI && eng_busy) begin
            state <= WAIT_LO;
          end
`ifdef RSA_ARB_TIMEOUT_EN
          wait_cnt <= wait_cnt + 1'b1;
`endif
        end
        RESP: begin
          resp_y <= '0;
`ifdef RSA_ARB_TIMEOUT_EN
          err    <= 1'b0;
`endif
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_arbiter.sv
// tb_rsa_arbiter: self-checking bench for rsa_arbiter with a behavioural
// engine and a round-robin / mod-exp reference model.
// Honours RSA_ARB_TIMEOUT_EN for the stuck-engine scenario.
module tb_rsa_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TMO = 16;
`ifdef RSA_ARB_TIMEOUT_EN
  localparam int LONG = 8;
`else
  localparam int LONG = 20;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N*W-1:0] req_c = '0;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_y;
  logic           resp_err;
  logic           eng_start;
  logic [W-1:0]   eng_a;
  logic [W-1:0]   eng_b;
  logic [W-1:0]   eng_c;
  logic           eng_busy = 1'b0;
  logic [W-1:0]   eng_y = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Behavioural engine knobs (written by the stimulus only).
  int eng_delay = 1;
  int eng_len   = LONG;
  bit eng_stuck = 1'b0;

  int           rise_cnt = 0;
  int           run_cnt  = 0;
  logic [W-1:0] eng_res  = '0;

  // Reference model state.
  int           model_last = N - 1;
  int           exp_idx_q[$];
  logic [W-1:0] exp_y_q[$];
  int           ack_order[$];
  logic [N-1:0] rereq = '0;
  int           reraise_left = 0;
  int           last_resp_cyc = 0;
  logic [W-1:0] last_resp_y = '0;

  rsa_arbiter #(.N(N), .W(W), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_c      (req_c),
    .req_ack    (req_ack),
    .resp_valid (resp_valid),
    .resp_y     (resp_y),
    .resp_err   (resp_err),
    .eng_start  (eng_start),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_c      (eng_c),
    .eng_busy   (eng_busy),
    .eng_y      (eng_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] modexp(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
    int r;
    r = 1 % int'(c);
    for (int i = 0; i < int'(b); i++) r = (r * int'(a)) % int'(c);
    return W'(r);
  endfunction

  function automatic int rr_model(input logic [N-1:0] r, input int from);
    for (int k = 1; k <= N; k++) if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  // Engine: busy rises eng_delay cycles after start, stays eng_len cycles.
  always @(posedge clk) begin
    if (eng_start) begin
      eng_res  <= modexp(eng_a, eng_b, eng_c);
      rise_cnt <= eng_delay;
      run_cnt  <= eng_len;
    end else if (rise_cnt > 0) begin
      rise_cnt <= rise_cnt - 1;
      if (rise_cnt == 1) eng_busy <= 1'b1;
    end else if (eng_busy && !eng_stuck) begin
      if (run_cnt <= 1) begin
        eng_busy <= 1'b0;
        eng_y    <= eng_res;
      end
      run_cnt <= run_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_c[i*W +: W] = c;
  endtask

  // Serve requesters until every request is answered, checking each ack/resp.
  task automatic run_jobs(input int budget);
    int           n;
    bit           done;
    int           w;
    int           idx;
    logic [W-1:0] y;
    logic [N-1:0] raise_now;
    logic [N-1:0] raise_new;
    n = 0; done = 1'b0; raise_now = '0; raise_new = '0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      if (req_ack !== '0) begin
        w = rr_model(req, model_last);
        check("ack_onehot", 32'($onehot(req_ack)), 32'd1);
        check("ack_winner", 32'(req_ack), (w >= 0) ? 32'(1 << w) : 32'd0);
        check("ack_eng_start", 32'(eng_start), 32'd1);
        check("ack_eng_idle", 32'(eng_busy), 32'd0);
        if (w >= 0) begin
          check("ack_eng_a", 32'(eng_a), 32'(req_a[w*W +: W]));
          check("ack_eng_b", 32'(eng_b), 32'(req_b[w*W +: W]));
          check("ack_eng_c", 32'(eng_c), 32'(req_c[w*W +: W]));
          exp_idx_q.push_back(w);
          exp_y_q.push_back(modexp(req_a[w*W +: W], req_b[w*W +: W], req_c[w*W +: W]));
          ack_order.push_back(w);
          $display("t=%0d ack requester %0d", cyc, w);
          model_last = w;
          req[w] = 1'b0;
          if (rereq[w] && reraise_left > 0) begin
            raise_new[w] = 1'b1;
            reraise_left--;
          end
        end
      end
      if (resp_valid !== '0) begin
        check("resp_onehot", 32'($onehot(resp_valid)), 32'd1);
        if (exp_idx_q.size() == 0) begin
          check("resp_unexpected", 32'(resp_valid), 32'd0);
        end else begin
          idx = exp_idx_q.pop_front();
          y   = exp_y_q.pop_front();
          check("resp_owner", 32'(resp_valid), 32'(1 << idx));
          check("resp_y", 32'(resp_y), 32'(y));
          check("resp_err", 32'(resp_err), 32'd0);
          last_resp_cyc = cyc;
          last_resp_y   = resp_y;
          $display("t=%0d resp requester %0d y=%02h", cyc, idx, resp_y);
        end
      end
      req       = req | raise_now;
      raise_now = raise_new;
      raise_new = '0;
      done = (req == '0) && (raise_now == '0) && (exp_idx_q.size() == 0);
    end
    check("run_budget", 32'(done), 32'd1);
    @(negedge clk);
    check("resp_y_cleared", 32'(resp_y), 32'd0);
    check("resp_valid_cleared", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int           c0;
    int           seen_ack;
    int           seen_resp;
    int           resp_cyc;
    logic [W-1:0] got_y;
    logic         got_err;
    logic [N-1:0] got_v;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ack", 32'(req_ack), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_y", 32'(resp_y), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_eng_a", 32'(eng_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Contention: all four request together, expect 0,1,2,3.
    for (int i = 0; i < N; i++)
      set_ops(i, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), W'($urandom_range(2, 255)));
    eng_len = $urandom_range(3, 8);
    ack_order.delete();
    req = '1;
    run_jobs(400);
    check("contention_count", 32'(ack_order.size()), 32'd4);
    for (int k = 0; k < ack_order.size() && k < N; k++)
      check("contention_order", 32'(ack_order[k]), 32'(k));

    // Fairness: requesters 0 and 2 keep re-requesting, expect 0,2,0,2.
    repeat (2) @(negedge clk);
    set_ops(0, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), W'($urandom_range(2, 255)));
    set_ops(2, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), W'($urandom_range(2, 255)));
    rereq = 4'b0101;
    reraise_left = 2;
    ack_order.delete();
    req = 4'b0101;
    run_jobs(400);
    rereq = '0;
    check("fair_count", 32'(ack_order.size()), 32'd4);
    for (int k = 0; k < ack_order.size() && k < 4; k++)
      check("fair_order", 32'(ack_order[k]), 32'((k % 2) * 2));

    // Single job with the reference vector.
    repeat (2) @(negedge clk);
    eng_len = LONG;
    eng_delay = 1;
    set_ops(1, 8'h2b, 8'h05, 8'h3a);
    ack_order.delete();
    req = 4'b0010;
    c0 = cyc;
    run_jobs(200);
    check("single_acks", 32'(ack_order.size()), 32'd1);
    check("single_y", 32'(last_resp_y), 32'h13);
    check("single_latency", 32'(last_resp_cyc - c0), 32'(LONG + 4));

    // Late busy: engine responds 5 cycles after start.
    repeat (2) @(negedge clk);
    eng_delay = 5;
    set_ops(3, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), W'($urandom_range(2, 255)));
    req = 4'b1000;
    c0 = cyc;
    run_jobs(200);
    check("late_latency", 32'(last_resp_cyc - c0), 32'(LONG + 8));
    eng_delay = 1;

    // Reset in WAIT_LO, then a requester-3 job after release.
    repeat (2) @(negedge clk);
    set_ops(3, W'($urandom_range(1, 255)), W'($urandom_range(1, 255)), W'($urandom_range(2, 255)));
    req = 4'b1000;
    seen_ack = 0;
    for (int k = 0; k < 10 && seen_ack == 0; k++) begin
      @(negedge clk);
      if (req_ack[3]) begin
        seen_ack = 1;
        req = '0;
      end
    end
    check("rst_mid_ack", 32'(seen_ack), 32'd1);
    repeat (5) @(negedge clk);
    check("rst_mid_engine_running", 32'(eng_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_eng_a", 32'(eng_a), 32'd0);
    check("rst_mid_eng_b", 32'(eng_b), 32'd0);
    check("rst_mid_eng_c", 32'(eng_c), 32'd0);
    check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mid_req_ack", 32'(req_ack), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_idx_q.delete();
    exp_y_q.delete();
    model_last = N - 1;
    set_ops(3, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), W'($urandom_range(2, 255)));
    req = 4'b1000;
    run_jobs(200);

    // Stuck engine: watchdog response, or no response at all.
    repeat (2) @(negedge clk);
    eng_stuck = 1'b1;
    set_ops(0, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), W'($urandom_range(2, 255)));
    req = 4'b0001;
    c0 = cyc;
    seen_ack = 0; seen_resp = 0; resp_cyc = 0; got_y = '0; got_err = 1'b0; got_v = '0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ack !== '0) begin
        seen_ack++;
        req = '0;
      end
      if (resp_valid !== '0) begin
        seen_resp++;
        resp_cyc = cyc;
        got_y = resp_y;
        got_err = resp_err;
        got_v = resp_valid;
      end
    end
    check("stuck_acks", 32'(seen_ack), 32'd1);
`ifdef RSA_ARB_TIMEOUT_EN
    check("tmo_resp_count", 32'(seen_resp), 32'd1);
    check("tmo_resp_owner", 32'(got_v), 32'd1);
    check("tmo_resp_err", 32'(got_err), 32'd1);
    check("tmo_resp_y", 32'(got_y), 32'd0);
    check("tmo_latency", 32'(resp_cyc - c0), 32'(TMO + 2));
    $display("t=%0d timeout resp err=%0d y=%02h", resp_cyc, got_err, got_y);
    set_ops(1, 8'h03, 8'h02, 8'h07);
    req = 4'b0010;
    seen_ack = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (req_ack !== '0) seen_ack++;
    end
    check("tmo_holdoff", 32'(seen_ack), 32'd0);
    req = '0;
`else
    check("stuck_no_resp", 32'(seen_resp), 32'd0);
    $display("t=%0d stuck engine, responses seen=%0d", cyc, seen_resp);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
